sp_memory_arb: RTL and testbench
================================

# sp_memory_arb

Round-robin arbiter that shares one `sp_memory` native port between `NUM_PORTS` requesters. It sits between the requester-side logic (APB wrappers, DMA, scrubber) and the `sp_memory` core. It accepts at most one access per cycle and drives the core's `cs`/`we`/`addr`/`wdata`/`wstrb`. Read data and read error status are returned to the requester that issued the read, after the core's read latency.

## Interface
Parameters:
- `NUM_PORTS`, 4: number of requesters, 2..8.
- `WIDTH`, 32: data width, multiple of 8.
- `DEPTH`, 1024: memory words; address width `AW = $clog2(DEPTH)`.
- `RD_LATENCY`, 1: core read latency in cycles, 1 or 2. Use 2 when `sp_memory` has `PIPELINE=1`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `req`  in  NUM_PORTS  per-port request valid.
- `req_we`  in  NUM_PORTS  per-port write flag.
- `req_addr`  in  NUM_PORTS*AW  per-port word address, packed (port i at `[i*AW +: AW]`).
- `req_wdata`  in  NUM_PORTS*WIDTH  per-port write data, packed.
- `req_wstrb`  in  NUM_PORTS*WIDTH/8  per-port byte strobes, packed.
- `gnt`  out  NUM_PORTS  one-hot accept; a transfer occurs when `req[i] & gnt[i]`.
- `rvalid`  out  NUM_PORTS  one-hot read-data valid.
- `rdata`  out  WIDTH  read data, common to all ports, qualified by `rvalid`.
- `rerr`  out  1  read error, qualified by `rvalid`.
- `hold`  in  1  block new grants; connect to `sleep | bist_en`.
- `mem_cs`  out  1  core chip select.
- `mem_we`  out  1  core write enable.
- `mem_addr`  out  AW  core address.
- `mem_wdata`  out  WIDTH  core write data.
- `mem_wstrb`  out  WIDTH/8  core byte strobes.
- `mem_rdata`  in  WIDTH  core read data.
- `mem_err`  in  1  core error, OR of `err_parity` and `err_ecc_double`. Must be valid with `mem_rdata`.

## Operation
- Priority pointer `ptr` (0..NUM_PORTS-1) names the highest-priority port. The search order is `ptr`, `ptr+1`, … with wrap modulo NUM_PORTS.
- `gnt` is combinational from `req`, `hold` and `ptr`. It goes to the first requesting port in search order. `gnt` is all-zero when `hold=1` or no port requests.
- On a grant to port k, `ptr` updates to `(k+1) mod NUM_PORTS` at the next edge. With no grant, `ptr` holds.
- The memory outputs mirror the granted port's signals in the same cycle:
  - `mem_cs=1`, `mem_we=req_we[k]`, `mem_addr`/`mem_wdata`/`mem_wstrb` = port k fields.
  - With no grant: `mem_cs=0`, `mem_we=0`, and the data/address outputs are 0.
- Read tracking uses a RD_LATENCY-deep shift register of {valid, port index}. A granted read enters the register. `rvalid[idx]` asserts when the entry exits, with `rdata=mem_rdata` and `rerr=mem_err`.
- Writes generate no response.
- Requesters must hold `req` and its fields stable until granted. Deasserting `req` before the grant is legal and drops the request.
- `hold` affects only new grants. Reads already in the tracker still return.

## Timing
- Reset (`rst_n=0` at an edge): `ptr=0`, tracker cleared.
  - During and after reset until the next grant: `gnt=0`, `rvalid=0`, `rdata=0`, `rerr=0`, and all `mem_*` outputs are 0.
  - `gnt` is forced to 0 while `rst_n=0`.
  - Reset mid-read discards outstanding responses; no `rvalid` is issued for them.
- Read grant at cycle N -> `rvalid` at cycle N+RD_LATENCY.
- Back-to-back grants are allowed every cycle, and at most one `rvalid` bit is set per cycle.
- A single requester can be granted every cycle: with only port k requesting, the pointer advances past k and k is still found on wrap.
- Fairness: under continuous requests from all ports, each port is granted exactly once every NUM_PORTS cycles.
- Rising `hold` in cycle N gives `gnt=0` in cycle N, because `hold` acts combinationally.

## Configuration
- `SP_MEMORY_ARB_PRIO0_EN`
  - Defined: port 0 is fixed highest priority. If `req[0]=1` and `hold=0`, port 0 is granted regardless of `ptr`, and `ptr` is not updated on a port-0 grant. Ports 1..NUM_PORTS-1 round-robin among themselves when port 0 is idle.
  - Undefined: pure round-robin over all ports as described above.

## Test plan
- After reset, all four ports request reads to addresses 0x10, 0x20, 0x30, 0x40 and hold `req` high -> grants in cycles 0, 1, 2, 3 in order 0, 1, 2, 3. `rvalid[0..3]` follow 1 cycle later with data pre-written at those addresses.
- Port 2 writes 0xDEADBEEF to addr 5 with `wstrb=4'b0011`, then reads addr 5 (initial content 0) -> `rdata=0x0000BEEF` with `rvalid[2]` only.
- `RD_LATENCY=2`, ports 1 and 3 read on consecutive cycles -> `rvalid[1]` at N+2 and `rvalid[3]` at N+3, each with correct data.
- Assert `hold` while port 0 has a read in flight -> the in-flight `rvalid[0]` is still delivered, and `gnt=0`/`mem_cs=0` until `hold` drops.
- Drive `rst_n=0` one cycle after a read grant -> no `rvalid` is issued, `ptr=0`, and the first post-reset grant goes to port 0.
- With `SP_MEMORY_ARB_PRIO0_EN`, ports 0 and 1 request continuously -> port 0 is granted every cycle and port 1 only after `req[0]` drops. Without the macro, grants alternate 0, 1, 0, 1.

Source files
------------

// File: rtl/sp_memory_arb.sv
// sp_memory_arb: round-robin arbiter sharing one sp_memory native port
// between NUM_PORTS requesters. Read responses are routed back to the
// issuing port after RD_LATENCY cycles through a {valid, index} tracker.
// Optional macro SP_MEMORY_ARB_PRIO0_EN: port 0 becomes fixed highest
// priority; the remaining ports round-robin when port 0 is idle.
module sp_memory_arb #(
  parameter  int NUM_PORTS  = 4,
  parameter  int WIDTH      = 32,
  parameter  int DEPTH      = 1024,
  parameter  int RD_LATENCY = 1,
  localparam int AW         = $clog2(DEPTH),
  localparam int SW         = WIDTH / 8,
  localparam int PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_PORTS-1:0]    req,
  input  logic [NUM_PORTS-1:0]    req_we,
  input  logic [NUM_PORTS*AW-1:0] req_addr,
  input  logic [NUM_PORTS*WIDTH-1:0] req_wdata,
  input  logic [NUM_PORTS*SW-1:0] req_wstrb,
  output logic [NUM_PORTS-1:0]    gnt,
  output logic [NUM_PORTS-1:0]    rvalid,
  output logic [WIDTH-1:0]        rdata,
  output logic                    rerr,
  input  logic                    hold,
  output logic                    mem_cs,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [WIDTH-1:0]        mem_wdata,
  output logic [SW-1:0]           mem_wstrb,
  input  logic [WIDTH-1:0]        mem_rdata,
  input  logic                    mem_err
);

  logic [PW-1:0]                  ptr;
  logic [PW-1:0]                  sel;
  logic                           found;
  logic                           grant_ok;
  logic                           rd_go;
  logic [RD_LATENCY:1]            vld_pipe;
  logic [RD_LATENCY:1][PW-1:0]    idx_pipe;
  logic                           rsp_vld;
  logic [PW-1:0]                  rsp_idx;

  // Priority search from ptr with wrap; iterating from the farthest offset
  // down leaves the nearest requester in sel.
  always_comb begin
    int idx;
    found = 1'b0;
    sel   = '0;
    for (int off = NUM_PORTS - 1; off >= 0; off--) begin
      idx = int'(ptr) + off;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (req[idx]) begin
        found = 1'b1;
        sel   = PW'(idx);
      end
    end
`ifdef SP_MEMORY_ARB_PRIO0_EN
    if (req[0]) begin
      found = 1'b1;
      sel   = '0;
    end
`endif
  end

  // Grant qualification; reset also blocks grants so nothing reaches the core.
  always_comb begin
    grant_ok = found & ~hold & rst_n;
    rd_go    = grant_ok & ~req_we[sel];
    gnt      = '0;
    if (grant_ok) gnt[sel] = 1'b1;
  end

  // Core port mirrors the granted requester; idle drives all zeros.
  always_comb begin
    mem_cs    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (grant_ok) begin
      mem_cs    = 1'b1;
      mem_we    = req_we[sel];
      mem_addr  = req_addr[int'(sel)*AW +: AW];
      mem_wdata = req_wdata[int'(sel)*WIDTH +: WIDTH];
      mem_wstrb = req_wstrb[int'(sel)*SW +: SW];
    end
  end

  // Pointer moves just past the granted port; a fixed-priority port 0
  // grant leaves the rotation among the other ports undisturbed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_ok
`ifdef SP_MEMORY_ARB_PRIO0_EN
                 && (sel != '0)
`endif
                ) begin
      ptr <= (sel == PW'(NUM_PORTS - 1)) ? '0 : sel + PW'(1);
    end
  end

  // Read tracker: {valid, port} shifts in step with the core read latency.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[1] <= rd_go;
      idx_pipe[1] <= sel;
      for (int s = 2; s <= RD_LATENCY; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        idx_pipe[s] <= idx_pipe[s-1];
      end
    end
  end

  // Response routing; data and error are zeroed unless a response exits,
  // and a response pending at a reset edge is dropped.
  always_comb begin
    rsp_vld = vld_pipe[RD_LATENCY] & rst_n;
    rsp_idx = idx_pipe[RD_LATENCY];
    rvalid  = '0;
    if (rsp_vld) rvalid[rsp_idx] = 1'b1;
    rdata   = rsp_vld ? mem_rdata : '0;
    rerr    = rsp_vld & mem_err;
  end

endmodule

// File: tb/tb_sp_memory_arb.sv
// Bench for sp_memory_arb: two instances (read latency 1 and 2) share the
// same request stimulus, each behind its own behavioral core model.
// Grants are checked inline; read responses go through per-instance
// scoreboards checked by negedge monitors.
module tb_sp_memory_arb;
  localparam int NP = 4, W = 32, D = 1024, AW = 10, SW = 4;
  localparam logic [AW-1:0] ERR_ADDR = 10'h030;

  logic clk = 1'b0, rst_n = 1'b0, hold = 1'b0;
  logic [NP-1:0] req = '0, req_we = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*W-1:0]  req_wdata = '0;
  logic [NP*SW-1:0] req_wstrb = '0;

  logic [NP-1:0] gnt1, rvalid1, gnt2, rvalid2;
  logic [W-1:0]  rdata1, rdata2, m1_wdata, m2_wdata, m1_rdata, m2_rdata, m2_stage;
  logic          rerr1, rerr2, m1_cs, m1_we, m2_cs, m2_we, m1_err, m2_err, m2_err_stage;
  logic [AW-1:0] m1_addr, m2_addr;
  logic [SW-1:0] m1_wstrb, m2_wstrb;
  logic [W-1:0]  mem1 [0:D-1];
  logic [W-1:0]  mem2 [0:D-1];

  int cyc = 0, nvec = 0, nerr = 0;

  typedef struct { int cyc; logic [NP-1:0] port; logic [W-1:0] data; logic err; } rsp_t;
  rsp_t q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sp_memory_arb #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D), .RD_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .gnt(gnt1), .rvalid(rvalid1),
    .rdata(rdata1), .rerr(rerr1), .hold(hold), .mem_cs(m1_cs), .mem_we(m1_we),
    .mem_addr(m1_addr), .mem_wdata(m1_wdata), .mem_wstrb(m1_wstrb),
    .mem_rdata(m1_rdata), .mem_err(m1_err));

  sp_memory_arb #(.NUM_PORTS(NP), .WIDTH(W), .DEPTH(D), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .gnt(gnt2), .rvalid(rvalid2),
    .rdata(rdata2), .rerr(rerr2), .hold(hold), .mem_cs(m2_cs), .mem_we(m2_we),
    .mem_addr(m2_addr), .mem_wdata(m2_wdata), .mem_wstrb(m2_wstrb),
    .mem_rdata(m2_rdata), .mem_err(m2_err));

  // Core models: byte-strobed writes, registered reads, error on ERR_ADDR.
  always @(posedge clk) begin
    if (m1_cs && m1_we) begin
      for (int b = 0; b < SW; b++) if (m1_wstrb[b]) mem1[m1_addr][b*8 +: 8] <= m1_wdata[b*8 +: 8];
    end else if (m1_cs) begin
      m1_rdata <= mem1[m1_addr];
      m1_err   <= (m1_addr == ERR_ADDR);
    end
  end

  always @(posedge clk) begin
    if (m2_cs && m2_we) begin
      for (int b = 0; b < SW; b++) if (m2_wstrb[b]) mem2[m2_addr][b*8 +: 8] <= m2_wdata[b*8 +: 8];
    end else if (m2_cs) begin
      m2_stage     <= mem2[m2_addr];
      m2_err_stage <= (m2_addr == ERR_ADDR);
    end
    m2_rdata <= m2_stage;
    m2_err   <= m2_err_stage;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    nvec++;
    nerr++;
    $display("FAIL %s cyc=%0d", nm, cyc);
  endtask

  // Response monitor for the latency-1 instance.
  always @(negedge clk) begin
    rsp_t e;
    while (q1.size() > 0 && q1[0].cyc < cyc) begin
      flag("l1_missing_rvalid");
      void'(q1.pop_front());
    end
    if (rvalid1 != '0) begin
      if (q1.size() > 0 && q1[0].cyc == cyc) begin
        e = q1.pop_front();
        chk("l1_rvalid", 64'(rvalid1), 64'(e.port));
        chk("l1_rdata", 64'(rdata1), 64'(e.data));
        chk("l1_rerr", 64'(rerr1), 64'(e.err));
      end else flag("l1_unexpected_rvalid");
    end
  end

  // Response monitor for the latency-2 instance.
  always @(negedge clk) begin
    rsp_t e;
    while (q2.size() > 0 && q2[0].cyc < cyc) begin
      flag("l2_missing_rvalid");
      void'(q2.pop_front());
    end
    if (rvalid2 != '0) begin
      if (q2.size() > 0 && q2[0].cyc == cyc) begin
        e = q2.pop_front();
        chk("l2_rvalid", 64'(rvalid2), 64'(e.port));
        chk("l2_rdata", 64'(rdata2), 64'(e.data));
        chk("l2_rerr", 64'(rerr2), 64'(e.err));
      end else flag("l2_unexpected_rvalid");
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) next();
  endtask

  task automatic set_port(input int p, input logic r, input logic we, input logic [AW-1:0] a,
                          input logic [W-1:0] wd, input logic [SW-1:0] ws);
    req[p] = r;
    req_we[p] = we;
    req_addr[p*AW +: AW] = a;
    req_wdata[p*W +: W] = wd;
    req_wstrb[p*SW +: SW] = ws;
  endtask

  // Checks the grant cycle on both instances; a read grant with push set
  // schedules its response at cyc+1 (latency 1) and cyc+2 (latency 2).
  task automatic exp_gnt(input string nm, input logic [NP-1:0] g, input logic rd,
                         input logic [AW-1:0] a, input logic [W-1:0] d, input logic e,
                         input logic push);
    #1;
    chk({nm, "_gnt1"}, 64'(gnt1), 64'(g));
    chk({nm, "_gnt2"}, 64'(gnt2), 64'(g));
    chk({nm, "_cs"}, 64'(m1_cs), 64'(g != '0));
    chk({nm, "_we"}, 64'(m1_we), 64'((g != '0) && !rd));
    chk({nm, "_addr"}, 64'(m1_addr), (g != '0) ? 64'(a) : 64'd0);
    if (g == '0) chk({nm, "_wdata0"}, 64'(m1_wdata), 64'd0);
    if (g != '0 && rd && push) begin
      q1.push_back('{cyc + 1, g, d, e});
      q2.push_back('{cyc + 2, g, d, e});
    end
  endtask

  logic [W-1:0] t1_data [NP];

  initial begin
    for (int i = 0; i < D; i++) begin mem1[i] = '0; mem2[i] = '0; end
    mem1[10'h010] = 32'h1000_0010; mem2[10'h010] = 32'h1000_0010;
    mem1[10'h020] = 32'h2000_0020; mem2[10'h020] = 32'h2000_0020;
    mem1[10'h030] = 32'h3000_0030; mem2[10'h030] = 32'h3000_0030;
    mem1[10'h040] = 32'h4000_0040; mem2[10'h040] = 32'h4000_0040;
    t1_data[0] = 32'h1000_0010; t1_data[1] = 32'h2000_0020;
    t1_data[2] = 32'h3000_0030; t1_data[3] = 32'h4000_0040;

    // Reset with requests active: nothing may reach the core or requesters.
    for (int p = 0; p < NP; p++) set_port(p, 1'b1, 1'b1, 10'h3FF, 32'hFFFF_FFFF, 4'hF);
    next(); next();
    exp_gnt("rst", 4'b0000, 1'b0, '0, '0, 1'b0, 1'b0);
    chk("rst_wstrb", 64'(m1_wstrb), 64'd0);
    chk("rst_rvalid", 64'({rvalid1, rvalid2}), 64'd0);
    chk("rst_rdata", 64'({rdata1, rdata2}), 64'd0);
    chk("rst_rerr", 64'({rerr1, rerr2}), 64'd0);
    rst_n = 1'b1;
    req = '0;
    next();

    // Four ports read continuously: two full rounds in port order.
    for (int p = 0; p < NP; p++)
      set_port(p, 1'b1, 1'b0, AW'((p + 1) * 16), '0, '0);
    for (int c = 0; c < 8; c++) begin
      exp_gnt("rr", 4'(1 << (c % NP)), 1'b1, AW'((c % NP + 1) * 16), t1_data[c % NP],
              (c % NP) == 2, 1'b1);
      next();
    end
    idle(3);

    // Port 2 partial write then readback (ptr=0, single requester).
    set_port(2, 1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF, 4'b0011);
    exp_gnt("wr", 4'b0100, 1'b0, 10'h005, '0, 1'b0, 1'b0);
    chk("wr_wdata", 64'(m1_wdata), 64'h0000_0000_DEAD_BEEF);
    chk("wr_wstrb", 64'(m1_wstrb), 64'h3);
    next();
    set_port(2, 1'b1, 1'b0, 10'h005, '0, '0);
    exp_gnt("rdback", 4'b0100, 1'b1, 10'h005, 32'h0000_BEEF, 1'b0, 1'b1);
    next();
    idle(3);

    // Ports 1 and 3 read on consecutive cycles (ptr=3).
    set_port(1, 1'b1, 1'b0, 10'h020, '0, '0);
    exp_gnt("b2b_p1", 4'b0010, 1'b1, 10'h020, 32'h2000_0020, 1'b0, 1'b1);
    next();
    req[1] = 1'b0;
    set_port(3, 1'b1, 1'b0, 10'h040, '0, '0);
    exp_gnt("b2b_p3", 4'b1000, 1'b1, 10'h040, 32'h4000_0040, 1'b0, 1'b1);
    next();
    idle(3);

    // Hold while a port-0 read is in flight (ptr=0).
    set_port(0, 1'b1, 1'b0, 10'h010, '0, '0);
    exp_gnt("pre_hold", 4'b0001, 1'b1, 10'h010, 32'h1000_0010, 1'b0, 1'b1);
    next();
    hold = 1'b1;
    set_port(1, 1'b1, 1'b0, 10'h020, '0, '0);
    exp_gnt("hold_a", 4'b0000, 1'b1, '0, '0, 1'b0, 1'b0);
    next();
    exp_gnt("hold_b", 4'b0000, 1'b1, '0, '0, 1'b0, 1'b0);
    next();
    hold = 1'b0;
    exp_gnt("unhold_p1", 4'b0010, 1'b1, 10'h020, 32'h2000_0020, 1'b0, 1'b1);
    next();
    req[1] = 1'b0;
    exp_gnt("unhold_p0", 4'b0001, 1'b1, 10'h010, 32'h1000_0010, 1'b0, 1'b1);
    next();
    idle(3);

    // Reset one cycle after a read grant (ptr=1 -> 2 after the grant).
    set_port(1, 1'b1, 1'b0, 10'h020, '0, '0);
    exp_gnt("pre_rst", 4'b0010, 1'b1, 10'h020, '0, 1'b0, 1'b0);
    next();
    rst_n = 1'b0;
    set_port(2, 1'b1, 1'b0, 10'h030, '0, '0);
    exp_gnt("in_rst", 4'b0000, 1'b1, '0, '0, 1'b0, 1'b0);
    chk("in_rst_rvalid1", 64'(rvalid1), 64'd0);
    next();
    rst_n = 1'b1;
    req[1] = 1'b0;
    set_port(0, 1'b1, 1'b1, 10'h100, 32'h0000_0100, 4'hF);
    set_port(2, 1'b1, 1'b1, 10'h101, 32'h0000_0101, 4'hF);
    exp_gnt("post_rst", 4'b0001, 1'b0, 10'h100, '0, 1'b0, 1'b0);
    next();
    idle(3);

    // Ports 0 and 1 request continuously (ptr=1 after the port-0 grant).
    set_port(0, 1'b1, 1'b1, 10'h200, 32'h0000_0200, 4'hF);
    set_port(1, 1'b1, 1'b1, 10'h201, 32'h0000_0201, 4'hF);
    for (int c = 0; c < 4; c++) begin
`ifdef SP_MEMORY_ARB_PRIO0_EN
      exp_gnt("p01", 4'b0001, 1'b0, 10'h200, '0, 1'b0, 1'b0);
`else
      exp_gnt("p01", (c % 2 == 0) ? 4'b0010 : 4'b0001, 1'b0,
              (c % 2 == 0) ? 10'h201 : 10'h200, '0, 1'b0, 1'b0);
`endif
      next();
    end
    req[0] = 1'b0;
    exp_gnt("p1_only", 4'b0010, 1'b0, 10'h201, '0, 1'b0, 1'b0);
    next();
    idle(4);

    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
